ps2_keyboard_rx: RTL and testbench
==================================

// Module: ps2_keyboard_rx
// PURPOSE
//  PS/2 keyboard receive front end feeding the key-command decoder (switch_mode) in the production test core.
//  Synchronises and deglitches clkps2/dataps2, deframes 11-bit frames (start, 8 data LSB-first, odd parity, stop),
//  strips E0/F0 prefixes and presents one decoded scancode per key event as a single-cycle pulse on clk (7 MHz).
// PARAMETERS
//  CLKFREQ_KHZ  7000  frequency of clk in kHz
//  TIMEOUT_US   1000  max gap between PS/2 clock falling edges inside a frame before abort
//  FILTER_LEN   8     samples of identical level needed before filtered PS/2 clock changes state (>=2)
// PORTS
//  clk            in   1  system clock; single clock domain
//  rst            in   1  synchronous, active-high reset
//  clkps2         in   1  raw PS/2 clock line, asynchronous
//  dataps2        in   1  raw PS/2 data line, asynchronous
//  scancode       out  8  last decoded scancode; held until next valid
//  scancode_valid out  1  one-cycle pulse: scancode/extended/released are new
//  extended       out  1  E0 prefix preceded this code
//  released       out  1  F0 prefix preceded this code (key up)
//  busy           out  1  frame reception in progress (state != IDLE)
//  parity_err     out  1  one-cycle pulse: frame discarded on parity mismatch
//  frame_err      out  1  one-cycle pulse: bad stop bit or timeout abort
//  err_count      out  8  saturating error counter (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: all outputs 0, FSM IDLE, prefix flags cleared, timeout counter 0. Reset mid-frame discards the partial frame.
//  - Input path: 2-FF synchroniser on both lines; clock filter: FILTER_LEN-deep shift register; filtered clk -> 0 only
//    when all samples 0, -> 1 only when all 1, else holds. Data sampled from synchronised line delayed to match filter.
//  - Bit strobe: one-cycle pulse on filtered clk 1->0 transition; every frame bit is taken on its strobe.
//  - FSM (strobe-driven): IDLE -start=0-> DATA; IDLE with start=1 ignored (stays IDLE, no error).
//    DATA: shift 8 bits LSB-first, 3-bit counter, -> PARITY after 8th. PARITY: latch bit -> STOP.
//    STOP: check ^{data,parity}==1 and stop==1; then -> IDLE.
//  - Frame outcome on STOP strobe (outputs asserted the following clk cycle, i.e. 1-cycle latency):
//    parity bad -> parity_err; stop==0 (parity good) -> frame_err; both bad -> parity_err only.
//    good 0xE0 -> set extended flag, no valid. good 0xF0 -> set released flag, no valid.
//    other good byte -> scancode<=byte, extended/released<=flags, scancode_valid=1, flags cleared same cycle.
//  - Error frames clear both prefix flags.
//  - Timeout: counter clears on every strobe and in IDLE; increments while busy; at TOUT=CLKFREQ_KHZ*TIMEOUT_US/1000
//    cycles (7000 default, width $clog2(TOUT+1)) -> IDLE, frame_err pulse, prefix flags cleared.
//  - Strobe coinciding with timeout terminal count: timeout wins, strobe discarded.
//  - No host-to-device transmission; lines are inputs only.
// CONFIGURATION
//  PS2_RX_ERRCNT_EN defined: err_count increments on each parity_err or frame_err, saturates at 255, cleared only by rst.
//  Not defined: err_count tied to 8'h00, counter logic absent. All other behaviour identical.
// STRUCTURE
//  - Shared include ps2_defs.vh: FSM state encodings (IDLE, DATA, PARITY, STOP), PS2_PREFIX_EXT=8'hE0,
//    PS2_PREFIX_REL=8'hF0; reused by switch_mode and mousetest.
//  - One sub-module: ps2_line_filter (synchroniser + clock filter + strobe generation, params FILTER_LEN).
//  - Top of block: FSM, shift register, timeout counter, prefix flags, optional error counter.
// TESTING
//  Bench drives PS/2 frames at 12.5 kHz (40 us half-period), clk 7 MHz, defaults unless stated.
//  1 Frame 0x1C, parity 0 -> exactly one scancode_valid, scancode=0x1C, extended=0, released=0, no error pulses.
//  2 Frames F0,1C then E0,F0,75 -> two valid pulses total: (1C, ext=0, rel=1) then (75, ext=1, rel=1); flags 0 after.
//  3 Frame 0x1C with parity bit 1 -> parity_err one cycle, no valid; err_count=1 with PS2_RX_ERRCNT_EN, 0 without.
//  4 Six bits of a frame then idle 1.2 ms -> frame_err one cycle, busy=0; following good 0x29 -> valid, scancode=0x29.
//  5 3-cycle low glitches on clkps2 between bits of a 0x5A frame -> no extra strobes, scancode=0x5A decoded once.
//  6 rst pulsed for 1 cycle after 4th data bit of 0x1C, then frame 0x12 -> no output for 0x1C; valid with 0x12.

Source files
------------

// File: rtl/ps2_keyboard_rx_pkg.sv
// Shared definitions for the PS/2 keyboard receiver: FSM encodings, prefix bytes, widths.
`timescale 1ns/1ps
package ps2_keyboard_rx_pkg;

    localparam int unsigned SCAN_W   = 8;
    localparam int unsigned BITCNT_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

    localparam logic [SCAN_W-1:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [SCAN_W-1:0] PS2_PREFIX_REL = 8'hF0;

    // Odd parity over data plus parity bit holds when the XOR of all nine bits is 1.
    function automatic logic odd_parity_ok(input logic [SCAN_W-1:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 line conditioning: 2-FF synchronisers, FILTER_LEN-deep clock deglitcher,
// falling-edge bit strobe and data sample delayed to line up with the filtered clock.
`timescale 1ns/1ps
module ps2_line_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clkps2_i,
    input  logic dataps2_i,
    output logic strobe_o,
    output logic bit_o
);

    logic [1:0]            clk_sync_q;
    logic [1:0]            dat_sync_q;
    logic [FILTER_LEN-1:0] clk_hist_q;
    logic [FILTER_LEN-1:0] dat_hist_q;
    logic                  filt_q;
    logic                  strobe_q;
    logic                  bit_q;

    logic all_low_c;
    logic all_high_c;

    assign all_low_c  = ~|clk_hist_q;
    assign all_high_c = &clk_hist_q;

    // Lines idle high, so reset fills everything with 1 to avoid a spurious first strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync_q <= '1;
            dat_sync_q <= '1;
            clk_hist_q <= '1;
            dat_hist_q <= '1;
            filt_q     <= 1'b1;
            strobe_q   <= 1'b0;
            bit_q      <= 1'b1;
        end else begin
            clk_sync_q <= {clk_sync_q[0], clkps2_i};
            dat_sync_q <= {dat_sync_q[0], dataps2_i};
            clk_hist_q <= {clk_hist_q[FILTER_LEN-2:0], clk_sync_q[1]};
            dat_hist_q <= {dat_hist_q[FILTER_LEN-2:0], dat_sync_q[1]};
            if (all_low_c) begin
                filt_q <= 1'b0;
            end else if (all_high_c) begin
                filt_q <= 1'b1;
            end
            strobe_q <= filt_q & all_low_c;
            bit_q    <= dat_hist_q[FILTER_LEN-1];
        end
    end

    assign strobe_o = strobe_q;
    assign bit_o    = bit_q;

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: deframes 11-bit frames, strips E0/F0 prefixes, pulses one scancode per key event.
// Optional saturating error counter enabled by defining PS2_RX_ERRCNT_EN.
`timescale 1ns/1ps
module ps2_keyboard_rx
    import ps2_keyboard_rx_pkg::*;
#(
    parameter int unsigned CLKFREQ_KHZ = 7000,
    parameter int unsigned TIMEOUT_US  = 1000,
    parameter int unsigned FILTER_LEN  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clkps2,
    input  logic              dataps2,
    output logic [SCAN_W-1:0] scancode,
    output logic              scancode_valid,
    output logic              extended,
    output logic              released,
    output logic              busy,
    output logic              parity_err,
    output logic              frame_err,
    output logic [7:0]        err_count
);

    localparam int unsigned TOUT   = CLKFREQ_KHZ * TIMEOUT_US / 1000;
    localparam int unsigned TOUT_W = $clog2(TOUT + 1);

    ps2_state_e state_q, state_d;

    logic [SCAN_W-1:0]   shift_q, shift_d;
    logic [BITCNT_W-1:0] cnt_q, cnt_d;
    logic                par_q, par_d;
    logic [TOUT_W-1:0]   tout_q, tout_d;
    logic                ext_flag_q, ext_flag_d;
    logic                rel_flag_q, rel_flag_d;
    logic [SCAN_W-1:0]   scancode_q, scancode_d;
    logic                valid_q, valid_d;
    logic                extended_q, extended_d;
    logic                released_q, released_d;
    logic                perr_q, perr_d;
    logic                ferr_q, ferr_d;

    logic strobe_c;
    logic bit_c;
    logic tout_hit_c;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_line_filter (
        .clk       (clk),
        .rst       (rst),
        .clkps2_i  (clkps2),
        .dataps2_i (dataps2),
        .strobe_o  (strobe_c),
        .bit_o     (bit_c)
    );

    // Timeout wins over a strobe landing on the terminal count.
    assign tout_hit_c = (state_q != ST_IDLE) && (tout_q == TOUT_W'(TOUT));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (tout_hit_c) begin
            state_d = ST_IDLE;
        end else if (strobe_c) begin
            case (state_q)
                ST_IDLE:   if (!bit_c) state_d = ST_DATA;
                ST_DATA:   if (cnt_q == BITCNT_W'(7)) state_d = ST_PARITY;
                ST_PARITY: state_d = ST_STOP;
                ST_STOP:   state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        par_d      = par_q;
        ext_flag_d = ext_flag_q;
        rel_flag_d = rel_flag_q;
        scancode_d = scancode_q;
        extended_d = extended_q;
        released_d = released_q;
        valid_d    = 1'b0;
        perr_d     = 1'b0;
        ferr_d     = 1'b0;
        tout_d     = (state_q == ST_IDLE || strobe_c) ? '0 : tout_q + TOUT_W'(1);
        if (tout_hit_c) begin
            tout_d     = '0;
            ferr_d     = 1'b1;
            ext_flag_d = 1'b0;
            rel_flag_d = 1'b0;
        end else if (strobe_c) begin
            case (state_q)
                ST_IDLE:   cnt_d = '0;
                ST_DATA: begin
                    shift_d = {bit_c, shift_q[SCAN_W-1:1]};
                    cnt_d   = cnt_q + BITCNT_W'(1);
                end
                ST_PARITY: par_d = bit_c;
                ST_STOP: begin
                    if (!odd_parity_ok(shift_q, par_q)) begin
                        perr_d     = 1'b1;
                        ext_flag_d = 1'b0;
                        rel_flag_d = 1'b0;
                    end else if (!bit_c) begin
                        ferr_d     = 1'b1;
                        ext_flag_d = 1'b0;
                        rel_flag_d = 1'b0;
                    end else if (shift_q == PS2_PREFIX_EXT) begin
                        ext_flag_d = 1'b1;
                    end else if (shift_q == PS2_PREFIX_REL) begin
                        rel_flag_d = 1'b1;
                    end else begin
                        scancode_d = shift_q;
                        extended_d = ext_flag_q;
                        released_d = rel_flag_q;
                        valid_d    = 1'b1;
                        ext_flag_d = 1'b0;
                        rel_flag_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q    <= '0;
            cnt_q      <= '0;
            par_q      <= 1'b0;
            tout_q     <= '0;
            ext_flag_q <= 1'b0;
            rel_flag_q <= 1'b0;
            scancode_q <= '0;
            extended_q <= 1'b0;
            released_q <= 1'b0;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            par_q      <= par_d;
            tout_q     <= tout_d;
            ext_flag_q <= ext_flag_d;
            rel_flag_q <= rel_flag_d;
            scancode_q <= scancode_d;
            extended_q <= extended_d;
            released_q <= released_d;
            valid_q    <= valid_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
        end
    end

`ifdef PS2_RX_ERRCNT_EN
    logic [7:0] errcnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            errcnt_q <= 8'h00;
        end else if ((perr_q || ferr_q) && (errcnt_q != 8'hFF)) begin
            errcnt_q <= errcnt_q + 8'd1;
        end
    end

    assign err_count = errcnt_q;
`else
    assign err_count = 8'h00;
`endif

    assign scancode       = scancode_q;
    assign scancode_valid = valid_q;
    assign extended       = extended_q;
    assign released       = released_q;
    assign busy           = (state_q != ST_IDLE);
    assign parity_err     = perr_q;
    assign frame_err      = ferr_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Self-checking bench for ps2_keyboard_rx: frame table, hand-written corner sequences, randomized traffic vs a frame-level model.
`timescale 1ns/1ps
module tb_ps2_keyboard_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       clkps2;
    logic       dataps2;
    logic [7:0] scancode;
    logic       scancode_valid;
    logic       extended;
    logic       released;
    logic       busy;
    logic       parity_err;
    logic       frame_err;
    logic [7:0] err_count;

    always #71 clk = ~clk;

    ps2_keyboard_rx dut (
        .clk            (clk),
        .rst            (rst),
        .clkps2         (clkps2),
        .dataps2        (dataps2),
        .scancode       (scancode),
        .scancode_valid (scancode_valid),
        .extended       (extended),
        .released       (released),
        .busy           (busy),
        .parity_err     (parity_err),
        .frame_err      (frame_err),
        .err_count      (err_count)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Output monitor: counts cycles each pulse is high and remembers the last decoded event.
    int         mon_valid = 0;
    int         mon_perr  = 0;
    int         mon_ferr  = 0;
    logic [7:0] mon_code  = 8'h00;
    logic       mon_ext   = 1'b0;
    logic       mon_rel   = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (scancode_valid) begin
                mon_valid <= mon_valid + 1;
                mon_code  <= scancode;
                mon_ext   <= extended;
                mon_rel   <= released;
            end
            if (parity_err) mon_perr <= mon_perr + 1;
            if (frame_err)  mon_ferr <= mon_ferr + 1;
        end
    end

    int s_valid, s_perr, s_ferr;
    int exp_errs = 0;
    int half_ns  = 5000;

    typedef struct {
        logic [7:0] d;
        bit         bp;
        bit         bs;
        int         ev;
        logic [7:0] code;
        logic       ext;
        logic       rel;
        int         pe;
        int         fe;
    } vec_t;

    vec_t tbl[18];

    task automatic cmp(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] d, input bit bp, input bit bs);
        return {~bs, (~^d) ^ bp, d, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] f, input int nbits, input bit glitch);
        for (int i = 0; i < nbits; i++) begin
            dataps2 = f[i];
            #(half_ns / 2);
            clkps2 = 1'b0;
            #(half_ns);
            clkps2 = 1'b1;
            if (glitch) begin
                #1000;
                clkps2 = 1'b0;
                #426;
                clkps2 = 1'b1;
                #(half_ns / 2 - 1426);
            end else begin
                #(half_ns / 2);
            end
        end
        dataps2 = 1'b1;
    endtask

    task automatic snap();
        s_valid = mon_valid;
        s_perr  = mon_perr;
        s_ferr  = mon_ferr;
    endtask

    task automatic check(input string nm, input int ev, input logic [7:0] code,
                         input logic ext, input logic rel, input int pe, input int fe);
        int exp_cnt;
        repeat (30) @(posedge clk);
        #1;
        cmp({nm, " valid_pulses"}, mon_valid - s_valid, ev);
        if (ev == 1) begin
            cmp({nm, " scancode"}, int'(mon_code), int'(code));
            cmp({nm, " extended"}, int'(mon_ext), int'(ext));
            cmp({nm, " released"}, int'(mon_rel), int'(rel));
        end
        cmp({nm, " parity_err_cycles"}, mon_perr - s_perr, pe);
        cmp({nm, " frame_err_cycles"}, mon_ferr - s_ferr, fe);
        cmp({nm, " busy"}, int'(busy), 0);
        exp_errs += pe + fe;
`ifdef PS2_RX_ERRCNT_EN
        exp_cnt = (exp_errs > 255) ? 255 : exp_errs;
`else
        exp_cnt = 0;
`endif
        cmp({nm, " err_count"}, int'(err_count), exp_cnt);
    endtask

    initial begin
        #15_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit         m_ext, m_rel;
        logic [7:0] d;
        bit         bp, bs;
        int         ev, pe, fe;
        logic [7:0] code;
        logic       e_ext, e_rel;

        tbl[0]  = '{8'h1C, 0, 0, 1, 8'h1C, 0, 0, 0, 0};
        tbl[1]  = '{8'hF0, 0, 0, 0, 8'h00, 0, 0, 0, 0};
        tbl[2]  = '{8'h1C, 0, 0, 1, 8'h1C, 0, 1, 0, 0};
        tbl[3]  = '{8'hE0, 0, 0, 0, 8'h00, 0, 0, 0, 0};
        tbl[4]  = '{8'hF0, 0, 0, 0, 8'h00, 0, 0, 0, 0};
        tbl[5]  = '{8'h75, 0, 0, 1, 8'h75, 1, 1, 0, 0};
        tbl[6]  = '{8'h1C, 1, 0, 0, 8'h00, 0, 0, 1, 0};
        tbl[7]  = '{8'h1C, 0, 1, 0, 8'h00, 0, 0, 0, 1};
        tbl[8]  = '{8'hE0, 0, 0, 0, 8'h00, 0, 0, 0, 0};
        tbl[9]  = '{8'h1C, 1, 0, 0, 8'h00, 0, 0, 1, 0};
        tbl[10] = '{8'h5A, 0, 0, 1, 8'h5A, 0, 0, 0, 0};
        tbl[11] = '{8'hF0, 0, 0, 0, 8'h00, 0, 0, 0, 0};
        tbl[12] = '{8'h1C, 1, 1, 0, 8'h00, 0, 0, 1, 0};
        tbl[13] = '{8'h00, 0, 0, 1, 8'h00, 0, 0, 0, 0};
        tbl[14] = '{8'hFF, 0, 0, 1, 8'hFF, 0, 0, 0, 0};
        tbl[15] = '{8'hE0, 0, 0, 0, 8'h00, 0, 0, 0, 0};
        tbl[16] = '{8'hE0, 0, 1, 0, 8'h00, 0, 0, 0, 1};
        tbl[17] = '{8'h12, 0, 0, 1, 8'h12, 0, 0, 0, 0};

        rst     = 1'b1;
        clkps2  = 1'b1;
        dataps2 = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        cmp("reset scancode", int'(scancode), 0);
        cmp("reset valid", int'(scancode_valid), 0);
        cmp("reset extended", int'(extended), 0);
        cmp("reset released", int'(released), 0);
        cmp("reset busy", int'(busy), 0);
        cmp("reset parity_err", int'(parity_err), 0);
        cmp("reset frame_err", int'(frame_err), 0);
        cmp("reset err_count", int'(err_count), 0);
        rst = 1'b0;
        repeat (20) @(posedge clk);

        // Single frame at the nominal 12.5 kHz PS/2 rate.
        half_ns = 40000;
        snap();
        send_bits(mk_frame(8'h1C, 0, 0), 11, 0);
        check("nominal_1C", 1, 8'h1C, 0, 0, 0, 0);

        half_ns = 5000;
        for (int i = 0; i < 18; i++) begin
            snap();
            send_bits(mk_frame(tbl[i].d, tbl[i].bp, tbl[i].bs), 11, 0);
            check($sformatf("tbl[%0d]", i), tbl[i].ev, tbl[i].code, tbl[i].ext, tbl[i].rel,
                  tbl[i].pe, tbl[i].fe);
        end

        // Truncated frame left idle beyond the timeout, then recovery.
        snap();
        send_bits(mk_frame(8'h29, 0, 0), 6, 0);
        repeat (30) @(posedge clk);
        #1;
        cmp("timeout busy_mid_frame", int'(busy), 1);
        #1_200_000;
        check("timeout_abort", 0, 8'h00, 0, 0, 0, 1);
        snap();
        send_bits(mk_frame(8'h29, 0, 0), 11, 0);
        check("after_timeout_29", 1, 8'h29, 0, 0, 0, 0);

        // Short low glitches on the PS/2 clock between bits must be filtered out.
        snap();
        send_bits(mk_frame(8'h5A, 0, 0), 11, 1);
        check("glitch_5A", 1, 8'h5A, 0, 0, 0, 0);

        // Reset mid-frame discards the partial frame.
        snap();
        send_bits(mk_frame(8'h1C, 0, 0), 5, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_errs = 0;
        cmp("midreset busy", int'(busy), 0);
        cmp("midreset scancode", int'(scancode), 0);
        repeat (20) @(posedge clk);
        send_bits(mk_frame(8'h12, 0, 0), 11, 0);
        check("after_reset_12", 1, 8'h12, 0, 0, 0, 0);

        // A lone strobe with data high in IDLE is not a start bit.
        snap();
        send_bits(11'h7FF, 1, 0);
        check("idle_high_bit", 0, 8'h00, 0, 0, 0, 0);
        snap();
        send_bits(mk_frame(8'h34, 0, 0), 11, 0);
        check("after_idle_bit_34", 1, 8'h34, 0, 0, 0, 0);

        // Randomized frames against a frame-level prefix model.
        m_ext = 0;
        m_rel = 0;
        for (int k = 0; k < 24; k++) begin
            case ($urandom_range(0, 9))
                0, 1:    d = 8'hE0;
                2, 3:    d = 8'hF0;
                default: d = 8'($urandom_range(0, 255));
            endcase
            bp = ($urandom_range(0, 7) == 0);
            bs = ($urandom_range(0, 7) == 0);
            ev = 0; pe = 0; fe = 0; code = 8'h00; e_ext = 0; e_rel = 0;
            if (bp) begin
                pe = 1; m_ext = 0; m_rel = 0;
            end else if (bs) begin
                fe = 1; m_ext = 0; m_rel = 0;
            end else if (d == 8'hE0) begin
                m_ext = 1;
            end else if (d == 8'hF0) begin
                m_rel = 1;
            end else begin
                ev = 1; code = d; e_ext = m_ext; e_rel = m_rel;
                m_ext = 0; m_rel = 0;
            end
            snap();
            send_bits(mk_frame(d, bp, bs), 11, 0);
            check($sformatf("rand[%0d] d=%02h", k, d), ev, code, e_ext, e_rel, pe, fe);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
